aes_key_expand_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 11 +
 rtl/aes_sbox.sv | 16 +
 rtl/aes_key_expand_iter.sv | 106 ++++++++++
 tb/tb_aes_key_expand_iter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, key-schedule FSM states and the GF(2^8) xtime helper
package aes_pkg;
  localparam int NK = 4;
  localparam int NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;
  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box (a: input byte, y: substituted byte)
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y = SBOX[{a, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_expand_iter.sv
// aes_key_expand_iter: iterative AES-128 key schedule, one round key per beat
//   clk, rst_n (sync, active-low); key_valid/key_ready/key: cipher key in;
//   rk_valid/rk_ready/rk/rk_idx/rk_last: round key stream out.
//   enc_dec=0 streams keys 0..10; enc_dec=1 buffers then emits 10..0.
//   Optional flush input when KEY_EXPAND_FLUSH_EN is defined.
module aes_key_expand_iter import aes_pkg::*; #(
  parameter bit enc_dec = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef KEY_EXPAND_FLUSH_EN
  input  logic         flush,
`endif
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [0:127] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);
  state_t st, nst;
  logic [7:0] rcon;
  logic [0:127] w, nk, bank_rd;
  logic [0:31] sw, t, n0, n1, n2, n3;
  logic accept, hs, last, fl;
`ifdef KEY_EXPAND_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  assign key_ready = st == IDLE;
  assign accept = key_valid && key_ready;
  assign hs = rk_valid && rk_ready;
  assign last = enc_dec ? rk_idx == 4'd0 : rk_idx == 4'(NR);
  assign rk_last = rk_valid && last;
  // SubWord(RotWord(w3)): byte i of the result comes from byte i+1 of w3
  for (genvar i = 0; i < 4; i++) begin : g_sb
    aes_sbox u_sb (.a(w[96 + 8 * ((i + 1) % 4) +: 8]), .y(sw[8 * i +: 8]));
  end
  assign t = sw ^ {rcon, 24'h0};
  assign n0 = w[0:31] ^ t;
  assign n1 = w[32:63] ^ n0;
  assign n2 = w[64:95] ^ n1;
  assign n3 = w[96:127] ^ n2;
  assign nk = {n0, n1, n2, n3};
  if (enc_dec) begin : g_bank
    logic [0:127] bank [0:NR];
    always_ff @(posedge clk)
      if (accept) bank[0] <= key;
      else if (st == EXPAND && rk_idx != 4'(NR)) bank[rk_idx + 4'd1] <= nk;
    // during EXPAND the index has reached NR when this read is consumed
    assign bank_rd = bank[st == EXPAND ? rk_idx : rk_idx - 4'd1];
  end else begin : g_nobank
    assign bank_rd = '0;
  end
  always_comb begin
    nst = st;
    if (st == IDLE && key_valid) nst = enc_dec ? EXPAND : EMIT;
    else if (st == EXPAND && rk_idx == 4'(NR)) nst = EMIT;
    else if (st == EMIT && hs && last) nst = IDLE;
    if (fl) nst = IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) st <= IDLE;
    else st <= nst;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_valid <= 1'b0;
      rk <= '0;
      rk_idx <= '0;
      rcon <= RCON_INIT;
      w <= '0;
    end else if (fl) begin
      rk_valid <= 1'b0;
      rcon <= RCON_INIT;
    end else if (accept) begin
      w <= key;
      rcon <= RCON_INIT;
      rk_idx <= '0;
      rk_valid <= !enc_dec;
      if (!enc_dec) rk <= key;
    end else if (st == EXPAND) begin
      if (rk_idx == 4'(NR)) begin
        rk <= bank_rd;
        rk_valid <= 1'b1;
      end else begin
        w <= nk;
        rcon <= xtime(rcon);
        rk_idx <= rk_idx + 4'd1;
      end
    end else if (st == EMIT && hs) begin
      if (last) rk_valid <= 1'b0;
      else if (enc_dec) begin
        rk <= bank_rd;
        rk_idx <= rk_idx - 4'd1;
      end else begin
        rk <= nk;
        w <= nk;
        rcon <= xtime(rcon);
        rk_idx <= rk_idx + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expand_iter.sv
// tb_aes_key_expand_iter: directed FIPS-197 key-schedule checks for enc and dec builds
module tb_aes_key_expand_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic e_kv, e_kr, e_rv, e_rr, e_last, d_kv, d_kr, d_rv, d_rr, d_last;
  logic [0:127] e_key, e_rk, d_key, d_rk;
  logic [3:0] e_idx, d_idx;
`ifdef KEY_EXPAND_FLUSH_EN
  logic e_flush, d_flush;
`endif
  logic [0:127] kexp [0:10];
  int pass_n = 0, total_n = 0;

  aes_key_expand_iter #(.enc_dec(1'b0)) u_enc (
    .clk(clk), .rst_n(rst_n),
`ifdef KEY_EXPAND_FLUSH_EN
    .flush(e_flush),
`endif
    .key_valid(e_kv), .key_ready(e_kr), .key(e_key),
    .rk_valid(e_rv), .rk_ready(e_rr), .rk(e_rk), .rk_idx(e_idx), .rk_last(e_last));

  aes_key_expand_iter #(.enc_dec(1'b1)) u_dec (
    .clk(clk), .rst_n(rst_n),
`ifdef KEY_EXPAND_FLUSH_EN
    .flush(d_flush),
`endif
    .key_valid(d_kv), .key_ready(d_kr), .key(d_key),
    .rk_valid(d_rv), .rk_ready(d_rr), .rk(d_rk), .rk_idx(d_idx), .rk_last(d_last));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    e_kv = 1'b0; e_rr = 1'b0; e_key = '0;
    d_kv = 1'b0; d_rr = 1'b0; d_key = '0;
`ifdef KEY_EXPAND_FLUSH_EN
    e_flush = 1'b0; d_flush = 1'b0;
`endif
    step; step;
    total_n++;
    if ({e_kr, e_rv, e_rk, e_idx, e_last} !== {1'b1, 1'b0, 128'h0, 4'h0, 1'b0})
      $display("FAIL reset_enc got kr=%b rv=%b rk=%h idx=%0d last=%b", e_kr, e_rv, e_rk, e_idx, e_last);
    else pass_n++;
    total_n++;
    if ({d_kr, d_rv, d_rk, d_idx, d_last} !== {1'b1, 1'b0, 128'h0, 4'h0, 1'b0})
      $display("FAIL reset_dec got kr=%b rv=%b rk=%h idx=%0d last=%b", d_kr, d_rv, d_rk, d_idx, d_last);
    else pass_n++;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_enc_stream;
    e_key = kexp[0]; e_kv = 1'b1;
    step;
    e_kv = 1'b0; e_rr = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      total_n++;
      if ({e_rv, e_last, e_idx, e_rk} !== {1'b1, i == 10, 4'(i), kexp[i]})
        $display("FAIL enc_beat%0d got rv=%b last=%b idx=%0d rk=%h want rk=%h", i, e_rv, e_last, e_idx, e_rk, kexp[i]);
      else pass_n++;
      if (i == 3) begin e_kv = 1'b1; e_key = '1; end
      if (i == 6) e_kv = 1'b0;
      step;
    end
    total_n++;
    if ({e_rv, e_kr} !== 2'b01) $display("FAIL enc_idle got rv=%b kr=%b want rv=0 kr=1", e_rv, e_kr);
    else pass_n++;
  endtask

  task automatic test_backpressure;
    e_key = kexp[0]; e_kv = 1'b1;
    step;
    e_kv = 1'b0; e_rr = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      total_n++;
      if ({e_rv, e_last, e_idx, e_rk} !== {1'b1, i == 10, 4'(i), kexp[i]})
        $display("FAIL bp_beat%0d got rv=%b last=%b idx=%0d rk=%h want rk=%h", i, e_rv, e_last, e_idx, e_rk, kexp[i]);
      else pass_n++;
      if (i == 3) begin
        e_rr = 1'b0;
        for (int h = 0; h < 5; h++) begin
          step;
          total_n++;
          if ({e_rv, e_idx, e_rk} !== {1'b1, 4'd3, kexp[3]})
            $display("FAIL bp_hold%0d got rv=%b idx=%0d rk=%h want idx=3 rk=%h", h, e_rv, e_idx, e_rk, kexp[3]);
          else pass_n++;
        end
        e_rr = 1'b1;
      end
      step;
    end
    total_n++;
    if ({e_rv, e_kr} !== 2'b01) $display("FAIL bp_idle got rv=%b kr=%b want rv=0 kr=1", e_rv, e_kr);
    else pass_n++;
  endtask

  task automatic test_dec;
    int c;
    d_key = kexp[0]; d_kv = 1'b1;
    step;
    d_kv = 1'b0; d_rr = 1'b1;
    c = 0;
    while (!d_rv && c < 30) begin step; c++; end
    total_n++;
    if (c !== 11) $display("FAIL dec_latency got %0d cycles want 11", c);
    else pass_n++;
    for (int i = 0; i <= 10; i++) begin
      total_n++;
      if ({d_rv, d_last, d_idx, d_rk} !== {1'b1, i == 10, 4'(10 - i), kexp[10 - i]})
        $display("FAIL dec_beat%0d got rv=%b last=%b idx=%0d rk=%h want rk=%h", i, d_rv, d_last, d_idx, d_rk, kexp[10 - i]);
      else pass_n++;
      step;
    end
    total_n++;
    if ({d_rv, d_kr} !== 2'b01) $display("FAIL dec_idle got rv=%b kr=%b want rv=0 kr=1", d_rv, d_kr);
    else pass_n++;
  endtask

  task automatic test_reset_mid;
    int n;
    e_key = kexp[0]; e_kv = 1'b1;
    step;
    e_kv = 1'b0; e_rr = 1'b1;
    repeat (5) step;
    total_n++;
    if ({e_idx, e_rk} !== {4'd5, kexp[5]}) $display("FAIL rst_pre got idx=%0d rk=%h want idx=5", e_idx, e_rk);
    else pass_n++;
    rst_n = 1'b0;
    step;
    total_n++;
    if ({e_rv, e_kr} !== 2'b01) $display("FAIL rst_abort got rv=%b kr=%b want rv=0 kr=1", e_rv, e_kr);
    else pass_n++;
    rst_n = 1'b1; e_key = '0; e_kv = 1'b1;
    step;
    e_kv = 1'b0;
    total_n++;
    if ({e_rv, e_idx, e_rk} !== {1'b1, 4'd0, 128'h0}) $display("FAIL rst_zero_b0 got rv=%b idx=%0d rk=%h", e_rv, e_idx, e_rk);
    else pass_n++;
    step;
    total_n++;
    if ({e_rv, e_idx, e_rk} !== {1'b1, 4'd1, 128'h62636363626363636263636362636363})
      $display("FAIL rst_zero_b1 got rv=%b idx=%0d rk=%h want rk=62636363626363636263636362636363", e_rv, e_idx, e_rk);
    else pass_n++;
    n = 0;
    while (e_rv && n < 20) begin step; n++; end
    total_n++;
    if (e_kr !== 1'b1) $display("FAIL rst_drain got kr=%b want 1", e_kr);
    else pass_n++;
  endtask

`ifdef KEY_EXPAND_FLUSH_EN
  task automatic test_flush;
    int n;
    e_key = kexp[0]; e_kv = 1'b1;
    step;
    e_kv = 1'b0; e_rr = 1'b1;
    repeat (7) step;
    e_flush = 1'b1;
    step;
    e_flush = 1'b0;
    total_n++;
    if ({e_rv, e_kr} !== 2'b01) $display("FAIL flush_idle got rv=%b kr=%b want rv=0 kr=1", e_rv, e_kr);
    else pass_n++;
    e_kv = 1'b1;
    step;
    e_kv = 1'b0;
    step;
    total_n++;
    if ({e_rv, e_idx, e_rk} !== {1'b1, 4'd1, kexp[1]}) $display("FAIL flush_rerun got rv=%b idx=%0d rk=%h want rk=%h", e_rv, e_idx, e_rk, kexp[1]);
    else pass_n++;
    n = 0;
    while (e_rv && n < 20) begin step; n++; end
  endtask
`endif

  initial begin
    kexp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    kexp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    kexp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    kexp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    kexp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    kexp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    kexp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    kexp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    kexp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    kexp[9]  = 128'hac7766f319fadc2128d12941575c006e;
    kexp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    test_reset;
    test_enc_stream;
    test_backpressure;
    test_dec;
    test_reset_mid;
`ifdef KEY_EXPAND_FLUSH_EN
    test_flush;
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
